// File: rtl/fma_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : fma_result_writer_pkg
// Brief  : Shared types and constants for the FMA result writer
//          (FSM state encoding, FP32 sign-bit index, ReLU zero value).
// Rev    : 1.0  initial release
// ============================================================================
package fma_result_writer_pkg;

  // Job FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // IEEE-754 single precision layout
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_WIDTH    = FP_SIGN_BIT + 1;

  // Value stored in place of a negative result when ReLU is enabled (+0.0)
  localparam logic [FP_WIDTH-1:0] RELU_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/fma_result_writer_if.sv
`default_nettype none
// ============================================================================
// Module : fma_result_writer_if
// Brief  : Bundles job parameters, FMA result stream, memory write port and
//          status of the result writer. slave = writer, master = environment.
// Rev    : 1.0  initial release
// ============================================================================
interface fma_result_writer_if #(
  parameter int LDW = 32,
  parameter int AW  = 32,
  parameter int WDW = 30
);
  // Job parameters
  logic           param_ena;
  logic [WDW-1:0] param_olength;
  logic [AW-1:0]  param_addr;
  logic           param_relu;
  // Result stream from the FMA (no back-pressure)
  logic           data_act;
  logic [LDW-1:0] data_out;
  // Memory write port
  logic           wr_req;
  logic [AW-1:0]  wr_addr;
  logic [LDW-1:0] wr_dat;
  logic           wr_ack;
  // Status
  logic           busy;
  logic           done;
  logic           ovf_err;

  modport slave (
    input  param_ena, param_olength, param_addr, param_relu,
    input  data_act, data_out, wr_ack,
    output wr_req, wr_addr, wr_dat, busy, done, ovf_err
  );

  modport master (
    output param_ena, param_olength, param_addr, param_relu,
    output data_act, data_out, wr_ack,
    input  wr_req, wr_addr, wr_dat, busy, done, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/fma_result_writer_sfifo.sv
`default_nettype none
// ============================================================================
// Module : fma_result_writer_sfifo
// Brief  : Synchronous FIFO, DEPTH x DW, with synchronous clear. A push while
//          full succeeds only when a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module fma_result_writer_sfifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // A pop frees the slot the simultaneous push needs, so full+push+pop is legal
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  // Storage array (no reset needed, occupancy is tracked by the counter)
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule
`default_nettype wire

// File: rtl/fma_result_writer.sv
`default_nettype none
// ============================================================================
// Module : fma_result_writer
// Brief  : Captures FMA results, optionally clamps negatives to +0.0, buffers
//          them and writes them to consecutive addresses over a req/ack port.
//          Pulses done once the requested number of results has been written.
// Rev    : 1.0  initial release
// ============================================================================
module fma_result_writer
  import fma_result_writer_pkg::*;
#(
  parameter int LDW = FP_WIDTH,
  parameter int AW  = 32,
  parameter int WDW = 30,
  parameter int FD  = 16,
  parameter int FAW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fma_result_writer_if.slave bus
);
  state_e         state_q, state_d;
  logic [WDW-1:0] olen_q, in_cnt_q;
  logic           relu_q;
  logic           cap_vld_q;
  logic [LDW-1:0] cap_dat_q;
  logic           wr_req_q;
  logic [AW-1:0]  wr_addr_q;
  logic [LDW-1:0] wr_dat_q;
  logic           ovf_q;

  logic           start, accept, pop;
  logic           fifo_full, fifo_empty;
  logic [LDW-1:0] fifo_head, capt;
  logic [FAW:0]   fifo_cnt;

  assign start  = bus.param_ena && (state_q == ST_IDLE);
  assign accept = bus.data_act && (state_q == ST_RUN) && (in_cnt_q < olen_q);
  assign pop    = wr_req_q && bus.wr_ack;
  // Sign bit set covers negatives, -0.0 and negative NaNs alike
  assign capt   = (relu_q && bus.data_out[LDW-1]) ? LDW'(RELU_ZERO) : bus.data_out;

  fma_result_writer_sfifo #(
    .DW    (LDW),
    .DEPTH (FD),
    .PW    (FAW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .push_i  (cap_vld_q),
    .din_i   (cap_dat_q),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; DRAIN waits for the capture stage, FIFO and port to empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.param_ena)
                  state_d = (bus.param_olength == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (in_cnt_q == olen_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((fifo_cnt == '0) && !wr_req_q && !cap_vld_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Job parameter latch, accepted-result counter and one-word capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      olen_q    <= '0;
      relu_q    <= 1'b0;
      in_cnt_q  <= '0;
      cap_vld_q <= 1'b0;
      cap_dat_q <= '0;
    end else begin
      if (start) begin
        olen_q   <= bus.param_olength;
        relu_q   <= bus.param_relu;
        in_cnt_q <= '0;
      end else if (accept) begin
        in_cnt_q <= in_cnt_q + WDW'(1);
      end
      cap_vld_q <= accept;
      if (accept) cap_dat_q <= capt;
    end
  end

  // Sticky overflow flag: a captured word met a full FIFO with no pop to make room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  ovf_q <= 1'b0;
    else if (start)                              ovf_q <= 1'b0;
    else if (cap_vld_q && fifo_full && !pop)     ovf_q <= 1'b1;
  end

  // Write port: present FIFO head when idle, pop and advance address on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else if (start) begin
      wr_addr_q <= bus.param_addr;
    end else if (pop) begin
      wr_req_q  <= 1'b0;
      wr_addr_q <= wr_addr_q + AW'(LDW / 8);
    end else if (!wr_req_q && !fifo_empty) begin
      wr_req_q  <= 1'b1;
      wr_dat_q  <= fifo_head;
    end
  end

  assign bus.wr_req  = wr_req_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_dat  = wr_dat_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.ovf_err = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_fma_result_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_fma_result_writer
// Brief  : Directed self-checking bench for fma_result_writer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fma_result_writer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_result_writer_if #(.LDW(32), .AW(32), .WDW(30)) bus ();

  fma_result_writer #(
    .LDW(32), .AW(32), .WDW(30), .FD(16), .FAW(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int ack_mode = 0;   // 0: never ack, 1: ack one cycle after req, 2: ack immediately
  int req_age  = 0;
  int done_cnt = 0;
  int done_base;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Memory-side responder
  always @(negedge clk) begin
    if (bus.wr_req) req_age = req_age + 1;
    else            req_age = 0;
    case (ack_mode)
      0:       bus.wr_ack = 1'b0;
      1:       bus.wr_ack = (req_age >= 2);
      default: bus.wr_ack = bus.wr_req;
    endcase
  end

  // Log accepted writes and done pulses
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.wr_req && bus.wr_ack) begin
        wa_q.push_back(bus.wr_addr);
        wd_q.push_back(bus.wr_dat);
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    return (i < wa_q.size()) ? wa_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [29:0] len, input logic [31:0] addr, input logic relu);
    bus.param_olength = len;
    bus.param_addr    = addr;
    bus.param_relu    = relu;
    bus.param_ena     = 1'b1;
    tick();
    bus.param_ena     = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    bus.data_act = 1'b1;
    bus.data_out = d;
    tick();
    bus.data_act = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.done) break;
      tick();
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    done_base = done_cnt;
  endtask

  initial begin
    bus.param_ena     = 1'b0;
    bus.param_olength = '0;
    bus.param_addr    = '0;
    bus.param_relu    = 1'b0;
    bus.data_act      = 1'b0;
    bus.data_out      = '0;
    done_base         = 0;

    // ---------------- reset state
    #12;
    chk("rst_wr_req", bus.wr_req, 1'b0);
    chk("rst_busy",   bus.busy,   1'b0);
    chk("rst_done",   bus.done,   1'b0);
    chk("rst_ovf",    bus.ovf_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- 1: basic job, ack one cycle after req
    ack_mode = 1;
    clear_log();
    start_job(30'd4, 32'h0000_0100, 1'b0);
    chk("t1_busy_start", bus.busy, 1'b1);
    send(32'h3F80_0000);
    send(32'h4000_0000);
    send(32'hC040_0000);
    send(32'h1234_5678);
    wait_done(200);
    chk("t1_done",      bus.done, 1'b1);
    chk("t1_busy_done", bus.busy, 1'b1);
    tick();
    chk("t1_done_pulse", bus.done, 1'b0);
    chk("t1_busy_fall",  bus.busy, 1'b0);
    repeat (3) tick();
    chk("t1_nwrites", wa_q.size(), 4);
    chk("t1_a0", wa(0), 32'h0000_0100);
    chk("t1_a1", wa(1), 32'h0000_0104);
    chk("t1_a2", wa(2), 32'h0000_0108);
    chk("t1_a3", wa(3), 32'h0000_010C);
    chk("t1_d0", wd(0), 32'h3F80_0000);
    chk("t1_d1", wd(1), 32'h4000_0000);
    chk("t1_d2", wd(2), 32'hC040_0000);
    chk("t1_d3", wd(3), 32'h1234_5678);
    chk("t1_done_cnt", done_cnt - done_base, 1);

    // ---------------- 2: ReLU
    ack_mode = 2;
    clear_log();
    start_job(30'd3, 32'h0000_0200, 1'b1);
    send(32'hBF80_0000);
    send(32'h8000_0000);
    send(32'h3F80_0000);
    wait_done(200);
    chk("t2_done", bus.done, 1'b1);
    repeat (2) tick();
    chk("t2_nwrites", wa_q.size(), 3);
    chk("t2_d0", wd(0), 32'h0000_0000);
    chk("t2_d1", wd(1), 32'h0000_0000);
    chk("t2_d2", wd(2), 32'h3F80_0000);
    chk("t2_a2", wa(2), 32'h0000_0208);

    // ---------------- 3: overflow with stalled write port
    ack_mode = 0;
    clear_log();
    start_job(30'd20, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 20; i++) send(32'h0000_1000 + 32'(i));
    repeat (3) tick();
    chk("t3_ovf",        bus.ovf_err, 1'b1);
    chk("t3_req_held",   bus.wr_req,  1'b1);
    chk("t3_head_dat",   bus.wr_dat,  32'h0000_1000);
    chk("t3_no_writes",  wa_q.size(), 0);
    chk("t3_busy_stall", bus.busy,    1'b1);
    ack_mode = 2;
    wait_done(400);
    chk("t3_done", bus.done, 1'b1);
    repeat (2) tick();
    chk("t3_nwrites", wa_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_d%0d", i), wd(i), 32'h0000_1000 + 32'(i));
    end
    chk("t3_a15", wa(15), 32'h0000_033C);
    chk("t3_done_cnt", done_cnt - done_base, 1);
    chk("t3_ovf_sticky", bus.ovf_err, 1'b1);

    // ---------------- 4: zero-length job, ignored inputs
    clear_log();
    start_job(30'd0, 32'h0000_0400, 1'b1);
    chk("t4_ovf_clr", bus.ovf_err, 1'b0);
    wait_done(3);
    chk("t4_done", bus.done, 1'b1);
    tick();
    chk("t4_done_pulse", bus.done, 1'b0);
    chk("t4_idle", bus.busy, 1'b0);
    send(32'h1111_1111);
    send(32'h2222_2222);
    repeat (10) tick();
    chk("t4_no_writes", wa_q.size(), 0);
    chk("t4_no_req", bus.wr_req, 1'b0);
    clear_log();
    start_job(30'd2, 32'h0000_0500, 1'b0);
    start_job(30'd5, 32'h0000_0900, 1'b1);   // busy: must be ignored
    send(32'hC000_0000);
    send(32'h4000_0000);
    wait_done(200);
    chk("t4_job_done", bus.done, 1'b1);
    repeat (2) tick();
    chk("t4_nwrites", wa_q.size(), 2);
    chk("t4_a0", wa(0), 32'h0000_0500);
    chk("t4_a1", wa(1), 32'h0000_0504);
    chk("t4_d0_norelu", wd(0), 32'hC000_0000);

    // ---------------- 5: asynchronous reset mid-job
    ack_mode = 0;
    clear_log();
    start_job(30'd20, 32'h0000_0600, 1'b0);
    for (int i = 0; i < 18; i++) send(32'h0000_2000 + 32'(i));
    repeat (2) tick();
    chk("t5_pre_ovf", bus.ovf_err, 1'b1);
    chk("t5_pre_req", bus.wr_req,  1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req",  bus.wr_req,  1'b0);
    chk("t5_rst_busy", bus.busy,    1'b0);
    chk("t5_rst_done", bus.done,    1'b0);
    chk("t5_rst_ovf",  bus.ovf_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    ack_mode = 2;
    clear_log();
    start_job(30'd2, 32'h0000_0700, 1'b0);
    send(32'hAAAA_0001);
    send(32'hAAAA_0002);
    wait_done(200);
    chk("t5_done", bus.done, 1'b1);
    repeat (2) tick();
    chk("t5_nwrites", wa_q.size(), 2);
    chk("t5_a0", wa(0), 32'h0000_0700);
    chk("t5_d1", wd(1), 32'hAAAA_0002);

    // ---------------- 6: address wrap
    ack_mode = 1;
    clear_log();
    start_job(30'd2, 32'hFFFF_FFFC, 1'b0);
    send(32'hAAAA_5555);
    send(32'h0BAD_F00D);
    wait_done(200);
    chk("t6_done", bus.done, 1'b1);
    repeat (2) tick();
    chk("t6_nwrites", wa_q.size(), 2);
    chk("t6_a0", wa(0), 32'hFFFF_FFFC);
    chk("t6_a1", wa(1), 32'h0000_0000);
    chk("t6_d1", wd(1), 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
